// File: rtl/btb_if.sv
// Fetch-side lookup and ID-side training signals of the branch target buffer.
// The BTB side uses the slave modport; fetch/ID logic (or a bench) uses master.
interface btb_if #(
  parameter int PC_W = 64
);
  logic            flush;
  logic            if_valid;
  logic [PC_W-1:0] if_pc;
  logic            pred_jump;
  logic            btb_hit;
  logic [PC_W-1:0] btb_target;
  logic [PC_W-1:0] npc;
  logic            id_update;
  logic [PC_W-1:0] id_pc;
  logic            id_taken;
  logic            id_uncond;
  logic [PC_W-1:0] id_target;

  modport master (
    output flush, if_valid, if_pc, pred_jump,
    output id_update, id_pc, id_taken, id_uncond, id_target,
    input  btb_hit, btb_target, npc
  );

  modport slave (
    input  flush, if_valid, if_pc, pred_jump,
    input  id_update, id_pc, id_taken, id_uncond, id_target,
    output btb_hit, btb_target, npc
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Two-way set-associative BTB with per-set LRU forming the next fetch PC.
// Optional perf counters are enabled by defining YSYX_22040931_BTB_PERF_EN.
module branch_target_buffer #(
  parameter int PC_W  = 64,
  parameter int SETS  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = PC_W - 2 - IDX_W
) (
  input  logic        clock,
  input  logic        reset,
`ifdef YSYX_22040931_BTB_PERF_EN
  output logic [31:0] perf_lookup,
  output logic [31:0] perf_hit,
`endif
  btb_if.slave        bus
);

  // No handshake: lookup is purely combinational and every cycle with
  // id_update=1 is consumed at the next rising edge.
  logic [SETS-1:0]  valid0, valid1, lru;
  logic [TAG_W-1:0] tag0 [SETS];
  logic [TAG_W-1:0] tag1 [SETS];
  logic [PC_W-1:0]  tgt0 [SETS];
  logic [PC_W-1:0]  tgt1 [SETS];
  logic [SETS-1:0]  unc0, unc1;

  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic             l_hit0, l_hit1, hit, hit_way, hit_uncond;
  logic             u_hit0, u_hit1, u_hit, u_way, victim, wr_way, wr_en;
  logic [PC_W-1:0]  hit_target;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{bus.if_pc[1:0], bus.id_pc[1:0]};

  assign l_idx  = bus.if_pc[2+IDX_W-1:2];
  assign l_tag  = bus.if_pc[PC_W-1:2+IDX_W];
  assign l_hit0 = valid0[l_idx] && (tag0[l_idx] == l_tag);
  assign l_hit1 = valid1[l_idx] && (tag1[l_idx] == l_tag);

  // Way 0 wins on a double match, which training never creates.
  assign hit        = bus.if_valid && (l_hit0 || l_hit1);
  assign hit_way    = !l_hit0;
  assign hit_uncond = hit_way ? unc1[l_idx] : unc0[l_idx];
  assign hit_target = hit ? (hit_way ? tgt1[l_idx] : tgt0[l_idx]) : '0;

  assign bus.btb_hit    = hit;
  assign bus.btb_target = hit_target;
  assign bus.npc        = (hit && (bus.pred_jump || hit_uncond)) ? hit_target
                                                                 : bus.if_pc + PC_W'(4);

  assign u_idx  = bus.id_pc[2+IDX_W-1:2];
  assign u_tag  = bus.id_pc[PC_W-1:2+IDX_W];
  assign u_hit0 = valid0[u_idx] && (tag0[u_idx] == u_tag);
  assign u_hit1 = valid1[u_idx] && (tag1[u_idx] == u_tag);
  assign u_hit  = u_hit0 || u_hit1;
  assign u_way  = !u_hit0;

  // Fill invalid ways first so a cold set never evicts a live entry.
  assign victim = !valid0[u_idx] ? 1'b0 :
                  !valid1[u_idx] ? 1'b1 : lru[u_idx];
  assign wr_way = u_hit ? u_way : victim;
  assign wr_en  = bus.id_update && (u_hit || bus.id_taken);

  // Update's LRU write is placed last so it overrides the lookup's.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else if (bus.flush) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (hit) lru[l_idx] <= ~hit_way;
      if (wr_en) begin
        if (wr_way) valid1[u_idx] <= 1'b1;
        else        valid0[u_idx] <= 1'b1;
        lru[u_idx] <= ~wr_way;
      end
    end
  end

  // Payload needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clock) begin
    if (wr_en && !bus.flush) begin
      if (wr_way) begin
        tag1[u_idx] <= u_tag;
        tgt1[u_idx] <= bus.id_target;
        unc1[u_idx] <= bus.id_uncond;
      end else begin
        tag0[u_idx] <= u_tag;
        tgt0[u_idx] <= bus.id_target;
        unc0[u_idx] <= bus.id_uncond;
      end
    end
  end

`ifdef YSYX_22040931_BTB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_lookup <= '0;
      perf_hit    <= '0;
    end else begin
      if (bus.if_valid && (perf_lookup != 32'hFFFF_FFFF)) perf_lookup <= perf_lookup + 32'd1;
      if (hit && (perf_hit != 32'hFFFF_FFFF))             perf_hit    <= perf_hit + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed scoreboard bench for branch_target_buffer: drivers queue expected
// {hit, target, npc} per lookup and a negedge monitor compares them.
module tb_branch_target_buffer;

  localparam int PC_W = 64;
  localparam int EW   = 1 + 2 * PC_W;

  logic clock;
  logic reset;

  btb_if #(.PC_W(PC_W)) bus ();

`ifdef YSYX_22040931_BTB_PERF_EN
  logic [31:0] perf_lookup, perf_hit;
`endif

  branch_target_buffer #(.PC_W(PC_W), .SETS(16), .IDX_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef YSYX_22040931_BTB_PERF_EN
    .perf_lookup (perf_lookup),
    .perf_hit    (perf_hit),
`endif
    .bus         (bus)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_lookups = 0;
  int n_hits    = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    if (bus.if_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_lookup: pc %h with empty queue", bus.if_pc);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        chk("btb_hit",    64'(bus.btb_hit), 64'(e[EW-1]));
        chk("btb_target", bus.btb_target,   e[2*PC_W-1:PC_W]);
        chk("npc",        bus.npc,          e[PC_W-1:0]);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic set_idle();
    bus.flush     = 1'b0;
    bus.if_valid  = 1'b0;
    bus.pred_jump = 1'b0;
    bus.id_update = 1'b0;
    bus.id_taken  = 1'b0;
    bus.id_uncond = 1'b0;
  endtask

  task automatic set_lookup(input logic [63:0] pc, input logic pj,
                            input logic eh, input logic [63:0] et, input logic [63:0] en);
    bus.if_valid  = 1'b1;
    bus.if_pc     = pc;
    bus.pred_jump = pj;
    exp_q.push_back({eh, et, en});
  endtask

  task automatic set_update(input logic [63:0] pc, input logic tk, input logic un, input logic [63:0] tg);
    bus.id_update = 1'b1;
    bus.id_pc     = pc;
    bus.id_taken  = tk;
    bus.id_uncond = un;
    bus.id_target = tg;
  endtask

  task automatic lookup(input logic [63:0] pc, input logic pj,
                        input logic eh, input logic [63:0] et, input logic [63:0] en);
    @(posedge clock); #1;
    set_idle();
    set_lookup(pc, pj, eh, et, en);
    n_lookups++;
    if (eh) n_hits++;
  endtask

  task automatic update(input logic [63:0] pc, input logic tk, input logic un, input logic [63:0] tg);
    @(posedge clock); #1;
    set_idle();
    set_update(pc, tk, un, tg);
  endtask

  task automatic check_perf(input string tag);
`ifdef YSYX_22040931_BTB_PERF_EN
    chk({tag, "_perf_lookup"}, 64'(perf_lookup), 64'(n_lookups));
    chk({tag, "_perf_hit"},    64'(perf_hit),    64'(n_hits));
`else
    if (tag.len() == 0) $display("[TB] untagged perf check");
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.if_pc = '0; bus.id_pc = '0; bus.id_target = '0;
    set_idle();
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // Lookup while reset is held: cold table.
    lookup(64'h8000_0000, 1'b1, 1'b0, 64'h0, 64'h8000_0004);
    @(negedge clock); #1;
    set_idle();
    reset = 1'b1;
    n_lookups = 0;
    n_hits    = 0;

    lookup(64'h8000_0000, 1'b1, 1'b0, 64'h0, 64'h8000_0004);
    update(64'h8000_0010, 1'b1, 1'b0, 64'h8000_0100);
    lookup(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 64'h8000_0014);
    lookup(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 64'h8000_0100);
    update(64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
    lookup(64'h8000_0020, 1'b0, 1'b1, 64'h8000_0400, 64'h8000_0400);

    // Set 4 replacement: 0x410 goes to way 1, then becomes LRU and is evicted.
    update(64'h8000_0410, 1'b1, 1'b0, 64'h8000_0500);
    lookup(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 64'h8000_0014);
    lookup(64'h8000_0410, 1'b1, 1'b1, 64'h8000_0500, 64'h8000_0500);
    lookup(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0100, 64'h8000_0014);
    update(64'h8000_0810, 1'b1, 1'b0, 64'h8000_0900);
    lookup(64'h8000_0410, 1'b1, 1'b0, 64'h0, 64'h8000_0414);
    lookup(64'h8000_0010, 1'b1, 1'b1, 64'h8000_0100, 64'h8000_0100);
    lookup(64'h8000_0810, 1'b1, 1'b1, 64'h8000_0900, 64'h8000_0900);

    // Not-taken update of a hit still rewrites target and uncond.
    update(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0200);
    lookup(64'h8000_0010, 1'b0, 1'b1, 64'h8000_0200, 64'h8000_0200);

    // Not-taken miss allocates nothing.
    update(64'h8000_0040, 1'b0, 1'b0, 64'h8000_0800);
    lookup(64'h8000_0040, 1'b1, 1'b0, 64'h0, 64'h8000_0044);

    // Same-cycle lookup and update: lookup sees the old table.
    @(posedge clock); #1;
    set_idle();
    set_lookup(64'h8000_0060, 1'b1, 1'b0, 64'h0, 64'h8000_0064);
    set_update(64'h8000_0060, 1'b1, 1'b0, 64'h8000_0600);
    n_lookups++;
    lookup(64'h8000_0060, 1'b1, 1'b1, 64'h8000_0600, 64'h8000_0600);

    // npc wraps modulo 2^64.
    lookup(64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 1'b0, 64'h0, 64'h0);

    // if_valid low suppresses a hit on a trained PC.
    @(posedge clock); #1;
    set_idle();
    bus.if_pc     = 64'h8000_0020;
    bus.pred_jump = 1'b1;
    #3;
    chk("novalid_hit",    64'(bus.btb_hit), 64'h0);
    chk("novalid_target", bus.btb_target,   64'h0);
    chk("novalid_npc",    bus.npc,          64'h8000_0024);

    // Flush wins over a same-cycle update.
    @(posedge clock); #1;
    set_idle();
    bus.flush = 1'b1;
    set_update(64'h8000_0030, 1'b1, 1'b1, 64'h8000_0700);
    lookup(64'h8000_0030, 1'b1, 1'b0, 64'h0, 64'h8000_0034);
    lookup(64'h8000_0010, 1'b1, 1'b0, 64'h0, 64'h8000_0014);
    lookup(64'h8000_0020, 1'b1, 1'b0, 64'h0, 64'h8000_0024);
    lookup(64'h8000_0810, 1'b1, 1'b0, 64'h0, 64'h8000_0814);
    lookup(64'h8000_0060, 1'b1, 1'b0, 64'h0, 64'h8000_0064);

    update(64'h8000_0020, 1'b1, 1'b1, 64'h8000_0400);
    lookup(64'h8000_0020, 1'b0, 1'b1, 64'h8000_0400, 64'h8000_0400);

    // Async reset between edges, held across one edge with an update pending.
    @(posedge clock); #1;
    set_idle();
    check_perf("pre_reset");
    set_lookup(64'h8000_0020, 1'b0, 1'b0, 64'h0, 64'h8000_0024);
    set_update(64'h8000_0070, 1'b1, 1'b0, 64'h8000_0A00);
    #1;
    reset = 1'b0;
    #1;
    chk("reset_hit_immediate", 64'(bus.btb_hit), 64'h0);
    check_perf_zero();
    fork
      begin #9; reset = 1'b1; end
    join_none
    n_lookups = 0;
    n_hits    = 0;

    lookup(64'h8000_0070, 1'b1, 1'b0, 64'h0, 64'h8000_0074);
    lookup(64'h8000_0020, 1'b0, 1'b0, 64'h0, 64'h8000_0024);
    @(posedge clock); #1;
    set_idle();
    check_perf("post_reset");

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected lookups never observed", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  task automatic check_perf_zero();
`ifdef YSYX_22040931_BTB_PERF_EN
    chk("reset_perf_lookup", 64'(perf_lookup), 64'h0);
    chk("reset_perf_hit",    64'(perf_hit),    64'h0);
`else
    chk("reset_npc", bus.npc, 64'h8000_0024);
`endif
  endtask

endmodule
